memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  MEM pipeline stage. Consumes ex_mem from execute, performs load/store over the data bus
//  (dreq/dresp), produces mem_wb for writeback. Drives the forward path back to execute's
//  forward1. Holds ok=0 while a bus transaction is outstanding, which stalls the pipeline.
// PARAMETERS
//  (none; widths come from common::word_t / addr_t)
// PORTS
//  clk           in   1        clock; all state updates on posedge clk
//  reset         in   1        synchronous, active-high
//  ex_mem_state  in   ex_mem   instruction from execute (valid, op, alu_result=addr, write_mem_data)
//  advance       in   1        global pipeline step; this stage's current instruction retires
//  dreq          out  dbus_req_t   valid, addr, size(msize_t), strobe[7:0], data
//  dresp         in   dbus_resp_t  addr_ok, data_ok, data
//  mem_wb_state  out  mem_wb   result to writeback (valid, inst, pc, rd, wdata, csr, trap, inst_counter)
//  forward       out  reg_writer   enable/dest/data of this stage's register write
//  ok            out  1        stage finished for the current instruction
// BEHAVIOUR
//  - Reset: state=IDLE, dreq.valid=0, done_ctr=0, rdata_q=0, ok=1, mem_wb_state.valid=0, forward.enable=0.
//  - Memory op = valid && op in {LB,LH,LW,LD,LBU,LHU,LWU,SB,SH,SW,SD}; non-memory ops pass through in 0 cycles, ok=1.
//  - FSM: IDLE -> REQ when memory op and inst_counter != done_ctr; REQ holds dreq.valid=1 and stable
//    addr/size/strobe/data until dresp.data_ok; REQ -> DONE on data_ok (latch rdata_q, done_ctr=inst_counter);
//    DONE -> IDLE on advance. ok=1 only in DONE (memory op) or IDLE (non-memory op).
//  - done_ctr prevents re-issuing the same access while the pipeline is stalled elsewhere.
//  - data_ok in the same cycle as request: DONE next cycle (1-cycle minimum latency).
//  - addr = alu_result; size from width (B=0,H=1,W=2,D=3); strobe = mask << addr[2:0];
//    store data = write_mem_data << (8*addr[2:0]).
//  - Load: extract (rdata >> 8*addr[2:0]); sign-extend for LB/LH/LW, zero-extend for LBU/LHU/LWU.
//  - forward.enable = valid && writes rd && rd!=0 && ok; loads forward only in DONE.
//  - Stores: forward.enable=0; mem_wb.wdata=0.
//  - csr/jump/trap fields of ex_mem copied unchanged to mem_wb.
//  - ex_mem.valid=0: no request, ok=1, mem_wb.valid=0.
//  - Reset mid-REQ: dreq.valid drops next cycle; the bus reply is discarded.
//  - mem_wb_state.valid=1 only when ok=1.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: addr[2:0] not aligned to the access size -> no bus request;
//    trap raised with mcause=4 (load) or 6 (store) and mtval=addr; rd not written; ok=1 in the same cycle.
//  Undefined: access is issued as-is; caller guarantees alignment; trap field passes through unchanged.
// STRUCTURE
//  common pkg: msize_t, dbus_req_t/dbus_resp_t, MCAUSE_LOAD_MISALIGN=4, MCAUSE_STORE_MISALIGN=6.
//  temp_storage pkg: mem_wb struct (add trap/mtval fields if absent).
//  Sub-module: mem_align (combinational: op, addr, wdata, rdata -> size, strobe, shifted wdata,
//    extended rdata, misaligned flag).
//  This module: FSM, done_ctr, rdata_q, output muxing.
// TESTING
//  1 SD addr=0x80000008 data=0x1122334455667788, data_ok after 3 cycles -> strobe=0xFF,
//    ok=0 for 3 cycles then 1, single request.
//  2 LB addr=...03, bus data byte3=0x80 -> wdata=0xFFFFFFFFFFFFFF80; LBU -> 0x80.
//  3 SW addr=...04 data=0xDEADBEEF -> strobe=0xF0, dreq.data[63:32]=0xDEADBEEF.
//  4 Load done, advance held 0 for 5 cycles -> exactly one dreq.valid pulse; forward stable.
//  5 ADD (non-memory) -> ok=1 same cycle, dreq.valid=0, mem_wb.wdata=alu_result.
//  6 MEM_MISALIGN_TRAP_EN, LW addr=...02 -> no dreq, trap mcause=4, mtval=addr;
//    reset asserted in REQ -> dreq.valid=0 next cycle.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared types for the MEM stage: bus structs, pipeline register structs and op decode helpers.
package memory_access_pkg;

  typedef logic [63:0] word_t;
  typedef logic [63:0] addr_t;
  typedef logic [31:0] counter_t;

  typedef enum logic [1:0] {
    MsizeB = 2'd0,
    MsizeH = 2'd1,
    MsizeW = 2'd2,
    MsizeD = 2'd3
  } msize_t;

  typedef enum logic [3:0] {
    OpAlu, OpBranch, OpJal,
    OpLb, OpLh, OpLw, OpLd, OpLbu, OpLhu, OpLwu,
    OpSb, OpSh, OpSw, OpSd
  } op_t;

  typedef enum logic [1:0] {StIdle, StReq, StDone} mem_state_e;

  localparam logic [3:0] McauseLoadMisalign  = 4'd4;
  localparam logic [3:0] McauseStoreMisalign = 4'd6;

  typedef struct packed {
    logic       valid;
    addr_t      addr;
    msize_t     size;
    logic [7:0] strobe;
    word_t      data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    word_t       wdata;
  } csr_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] mcause;
    word_t      mtval;
  } trap_t;

  typedef struct packed {
    logic        valid;
    op_t         op;
    logic [31:0] inst;
    addr_t       pc;
    logic [4:0]  rd;
    logic        wen;
    word_t       alu_result;
    word_t       write_mem_data;
    counter_t    inst_counter;
    csr_t        csr;
    logic        jump;
    trap_t       trap;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    addr_t       pc;
    logic [4:0]  rd;
    logic        wen;
    word_t       wdata;
    csr_t        csr;
    logic        jump;
    trap_t       trap;
    counter_t    inst_counter;
  } mem_wb_t;

  typedef struct packed {
    logic       enable;
    logic [4:0] dest;
    word_t      data;
  } reg_writer_t;

  function automatic logic is_load(op_t op);
    return op inside {OpLb, OpLh, OpLw, OpLd, OpLbu, OpLhu, OpLwu};
  endfunction

  function automatic logic is_store(op_t op);
    return op inside {OpSb, OpSh, OpSw, OpSd};
  endfunction

  function automatic msize_t op_size(op_t op);
    case (op)
      OpLb, OpLbu, OpSb: return MsizeB;
      OpLh, OpLhu, OpSh: return MsizeH;
      OpLw, OpLwu, OpSw: return MsizeW;
      default:           return MsizeD;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_mem_align.sv
// Combinational lane steering for the data bus: byte strobes, store shift, load extract/extend
// and an alignment check against the access size.
module memory_access_mem_align
  import memory_access_pkg::*;
(
  input  op_t        op,
  input  logic [2:0] offset,
  input  word_t      wdata,
  input  word_t      rdata,
  output msize_t     size,
  output logic [7:0] strobe,
  output word_t      wdata_shifted,
  output word_t      rdata_ext,
  output logic       misaligned
);

  logic [7:0] mask;
  logic [2:0] align_mask;
  word_t      rdata_sh;

  always_comb begin
    size = op_size(op);
    unique case (size)
      MsizeB: begin mask = 8'h01; align_mask = 3'b000; end
      MsizeH: begin mask = 8'h03; align_mask = 3'b001; end
      MsizeW: begin mask = 8'h0f; align_mask = 3'b011; end
      MsizeD: begin mask = 8'hff; align_mask = 3'b111; end
      default: begin mask = 8'hff; align_mask = 3'b111; end
    endcase

    strobe        = mask << offset;
    wdata_shifted = wdata << {offset, 3'b000};
    rdata_sh      = rdata >> {offset, 3'b000};
    misaligned    = (offset & align_mask) != 3'b000;

    unique case (op)
      OpLb:    rdata_ext = {{56{rdata_sh[7]}}, rdata_sh[7:0]};
      OpLh:    rdata_ext = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      OpLw:    rdata_ext = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      OpLbu:   rdata_ext = {56'd0, rdata_sh[7:0]};
      OpLhu:   rdata_ext = {48'd0, rdata_sh[15:0]};
      OpLwu:   rdata_ext = {32'd0, rdata_sh[31:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: issues loads/stores on the data bus and stalls via ok until the reply lands.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses trap instead of reaching the bus.
module memory_access
  import memory_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  ex_mem_t     ex_mem_state,
  input  logic        advance,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output mem_wb_t     mem_wb_state,
  output reg_writer_t forward,
  output logic        ok
);

  mem_state_e state_q, state_d;
  counter_t   done_ctr_q, done_ctr_d;
  word_t      rdata_q, rdata_d;

  logic       load_op, store_op, mem_op, misaligned, mis_trap;
  msize_t     size;
  logic [7:0] strobe;
  word_t      wdata_shifted, rdata_ext;

  memory_access_mem_align u_mem_align (
    .op           (ex_mem_state.op),
    .offset       (ex_mem_state.alu_result[2:0]),
    .wdata        (ex_mem_state.write_mem_data),
    .rdata        (rdata_q),
    .size         (size),
    .strobe       (strobe),
    .wdata_shifted(wdata_shifted),
    .rdata_ext    (rdata_ext),
    .misaligned   (misaligned)
  );

  assign load_op  = is_load(ex_mem_state.op);
  assign store_op = is_store(ex_mem_state.op);
  assign mem_op   = ex_mem_state.valid && (load_op || store_op);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_trap = mem_op && misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign mis_trap          = 1'b0;
`endif

  logic unused_addr_ok;
  assign unused_addr_ok = dresp.addr_ok;

  // done_ctr marks the instruction whose access already completed, so a stalled
  // pipeline never re-issues it.
  always_comb begin
    state_d    = state_q;
    done_ctr_d = done_ctr_q;
    rdata_d    = rdata_q;
    ok         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!mem_op || mis_trap) begin
          ok = 1'b1;
        end else if (ex_mem_state.inst_counter != done_ctr_q) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (dresp.data_ok) begin
          state_d    = StDone;
          rdata_d    = dresp.data;
          done_ctr_d = ex_mem_state.inst_counter;
        end
      end
      StDone: begin
        ok = 1'b1;
        if (advance) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dreq        = '0;
    dreq.valid  = (state_q == StReq);
    dreq.addr   = ex_mem_state.alu_result;
    dreq.size   = size;
    dreq.strobe = strobe;
    dreq.data   = wdata_shifted;

    mem_wb_state              = '0;
    mem_wb_state.valid        = ex_mem_state.valid && ok;
    mem_wb_state.inst         = ex_mem_state.inst;
    mem_wb_state.pc           = ex_mem_state.pc;
    mem_wb_state.rd           = ex_mem_state.rd;
    mem_wb_state.wen          = ex_mem_state.wen && !store_op && !mis_trap;
    mem_wb_state.csr          = ex_mem_state.csr;
    mem_wb_state.jump         = ex_mem_state.jump;
    mem_wb_state.trap         = ex_mem_state.trap;
    mem_wb_state.inst_counter = ex_mem_state.inst_counter;

    if (store_op || mis_trap) begin
      mem_wb_state.wdata = '0;
    end else if (load_op) begin
      mem_wb_state.wdata = rdata_ext;
    end else begin
      mem_wb_state.wdata = ex_mem_state.alu_result;
    end

    if (mis_trap) begin
      mem_wb_state.trap.valid  = 1'b1;
      mem_wb_state.trap.mcause = load_op ? McauseLoadMisalign : McauseStoreMisalign;
      mem_wb_state.trap.mtval  = ex_mem_state.alu_result;
    end

    // ok is only high in DONE for memory ops, so loads forward once data is in hand.
    forward.enable = ex_mem_state.valid && mem_wb_state.wen && (ex_mem_state.rd != 5'd0) && ok;
    forward.dest   = ex_mem_state.rd;
    forward.data   = mem_wb_state.wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      done_ctr_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_ctr_q <= done_ctr_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized accesses against
// a byte-level reference model; misalignment traps are exercised when MEM_MISALIGN_TRAP_EN is set.
module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        advance;
  ex_mem_t     ex_mem_state;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  mem_wb_t     mem_wb_state;
  reg_writer_t forward;
  logic        ok;

  int       checks   = 0;
  int       failures = 0;
  counter_t ctr      = 32'd1;

  always #5 clk = ~clk;

  memory_access dut (
    .clk         (clk),
    .reset       (reset),
    .ex_mem_state(ex_mem_state),
    .advance     (advance),
    .dreq        (dreq),
    .dresp       (dresp),
    .mem_wb_state(mem_wb_state),
    .forward     (forward),
    .ok          (ok)
  );

  typedef struct {
    int          ok_low;
    int          pulses;
    int          req_cycles;
    logic [7:0]  strobe;
    word_t       data;
    addr_t       addr;
    msize_t      size;
    bit          stable;
    word_t       wb_wdata;
    bit          wb_valid;
    bit          fwd_en;
    word_t       fwd_data;
    bit          fwd_stable;
    bit          timeout;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int ref_nbytes(op_t op);
    case (op)
      OpLb, OpLbu, OpSb: return 1;
      OpLh, OpLhu, OpSh: return 2;
      OpLw, OpLwu, OpSw: return 4;
      default:           return 8;
    endcase
  endfunction

  function automatic bit ref_is_store(op_t op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw) || (op == OpSd);
  endfunction

  function automatic bit ref_is_load(op_t op);
    return (op == OpLb) || (op == OpLh) || (op == OpLw) || (op == OpLd) ||
           (op == OpLbu) || (op == OpLhu) || (op == OpLwu);
  endfunction

  function automatic msize_t ref_size(int n);
    case (n)
      1:       return MsizeB;
      2:       return MsizeH;
      4:       return MsizeW;
      default: return MsizeD;
    endcase
  endfunction

  function automatic logic [7:0] ref_strobe(int n, int off);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < n; i++) if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  // Gather the addressed bytes one by one, then sign-extend by subtracting 2^(8n).
  function automatic word_t ref_load(op_t op, word_t rdata, int off);
    int         n;
    word_t      v;
    logic [7:0] b;
    n = ref_nbytes(op);
    v = '0;
    for (int i = 0; i < n; i++) begin
      b = rdata[8*(off+i) +: 8];
      v = v | (word_t'(b) << (8 * i));
    end
    if ((op == OpLb || op == OpLh || op == OpLw) && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v;
  endfunction

  function automatic ex_mem_t make_inst(op_t op, addr_t a, word_t wd, logic [4:0] rd);
    ex_mem_t e;
    e                = '0;
    e.valid          = 1'b1;
    e.op             = op;
    e.inst           = $urandom;
    e.pc             = {$urandom, $urandom};
    e.rd             = rd;
    e.wen            = 1'b1;
    e.alu_result     = a;
    e.write_mem_data = wd;
    e.inst_counter   = ctr;
    ctr              = ctr + 32'd1;
    return e;
  endfunction

  // ---------------- bus driver / observer ----------------
  task automatic drive_mem(input ex_mem_t inst, input word_t rdata, input int lat, input int hold,
                           output obs_t o);
    bit          prev_v;
    bit          done;
    int          cyc;
    reg_writer_t fsnap;
    prev_v = 1'b0; done = 1'b0; cyc = 0;
    o.ok_low = 0; o.pulses = 0; o.req_cycles = 0; o.strobe = '0; o.data = '0; o.addr = '0;
    o.size = MsizeB; o.stable = 1'b1; o.wb_wdata = '0; o.wb_valid = 1'b0; o.fwd_en = 1'b0;
    o.fwd_data = '0; o.fwd_stable = 1'b1; o.timeout = 1'b0;
    @(negedge clk);
    ex_mem_state = inst;
    advance      = 1'b0;
    dresp        = '0;
    while (!done && cyc < 40) begin
      #1;
      if (dreq.valid) begin
        o.req_cycles++;
        if (!prev_v) begin
          o.pulses++;
          if (o.pulses == 1) begin
            o.addr = dreq.addr; o.size = dreq.size; o.strobe = dreq.strobe; o.data = dreq.data;
          end
        end else if (dreq.addr !== o.addr || dreq.size !== o.size || dreq.strobe !== o.strobe ||
                     dreq.data !== o.data) begin
          o.stable = 1'b0;
        end
      end
      prev_v        = dreq.valid;
      dresp.data_ok = dreq.valid && (o.req_cycles == lat);
      dresp.data    = dresp.data_ok ? rdata : {$urandom, $urandom};
      #1;
      if (ok) done = 1'b1;
      else o.ok_low++;
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    o.timeout  = !done;
    o.wb_valid = mem_wb_state.valid;
    o.wb_wdata = mem_wb_state.wdata;
    o.fwd_en   = forward.enable;
    o.fwd_data = forward.data;
    fsnap      = forward;
    repeat (hold) begin
      @(negedge clk);
      dresp = '0;
      #1;
      if (dreq.valid && !prev_v) o.pulses++;
      prev_v = dreq.valid;
      if (forward !== fsnap || ok !== 1'b1) o.fwd_stable = 1'b0;
    end
    @(negedge clk);
    dresp   = '0;
    advance = 1'b1;
    @(negedge clk);
    advance            = 1'b0;
    ex_mem_state.valid = 1'b0;
    #1;
    if (dreq.valid) o.pulses++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset        = 1'b1;
    advance      = 1'b0;
    ex_mem_state = '0;
    dresp        = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dreq.valid !== 1'b0) begin
      failures++; $display("FAIL reset_dreq_valid got=%b exp=0", dreq.valid);
    end
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL reset_ok got=%b exp=1", ok); end
    checks++;
    if (mem_wb_state.valid !== 1'b0) begin
      failures++; $display("FAIL reset_wb_valid got=%b exp=0", mem_wb_state.valid);
    end
    checks++;
    if (forward.enable !== 1'b0) begin
      failures++; $display("FAIL reset_fwd_en got=%b exp=0", forward.enable);
    end
    reset = 1'b0;
  endtask

  task automatic test_store_dword();
    obs_t    o;
    ex_mem_t e;
    e = make_inst(OpSd, 64'h8000_0008, 64'h1122_3344_5566_7788, 5'd4);
    drive_mem(e, 64'h0, 2, 0, o);
    checks++;
    if (o.timeout || o.ok_low != 3) begin
      failures++; $display("FAIL sd_ok_low got=%0d exp=3 timeout=%b", o.ok_low, o.timeout);
    end
    checks++;
    if (o.pulses != 1) begin failures++; $display("FAIL sd_pulses got=%0d exp=1", o.pulses); end
    checks++;
    if (o.strobe !== 8'hff || o.size !== MsizeD || o.addr !== 64'h8000_0008) begin
      failures++;
      $display("FAIL sd_req strobe=%h size=%0d addr=%h exp ff/3/80000008", o.strobe, o.size, o.addr);
    end
    checks++;
    if (o.data !== 64'h1122_3344_5566_7788 || !o.stable) begin
      failures++; $display("FAIL sd_data got=%h stable=%b exp=1122334455667788", o.data, o.stable);
    end
    checks++;
    if (o.fwd_en !== 1'b0 || o.wb_wdata !== 64'h0 || o.wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL sd_wb fwd_en=%b wdata=%h valid=%b exp 0/0/1", o.fwd_en, o.wb_wdata, o.wb_valid);
    end
  endtask

  task automatic test_load_byte();
    obs_t    o;
    ex_mem_t e;
    e = make_inst(OpLb, 64'h8000_0003, 64'h0, 5'd5);
    drive_mem(e, 64'h1122_3344_8066_7788, 1, 0, o);
    checks++;
    if (o.wb_wdata !== 64'hffff_ffff_ffff_ff80 || o.fwd_en !== 1'b1 ||
        o.fwd_data !== 64'hffff_ffff_ffff_ff80) begin
      failures++;
      $display("FAIL lb_sext wdata=%h fwd_en=%b fwd=%h exp ffffffffffffff80", o.wb_wdata, o.fwd_en,
               o.fwd_data);
    end
    checks++;
    if (o.strobe !== 8'h08 || o.ok_low != 2) begin
      failures++; $display("FAIL lb_req strobe=%h ok_low=%0d exp 08/2", o.strobe, o.ok_low);
    end
    e = make_inst(OpLbu, 64'h8000_0003, 64'h0, 5'd5);
    drive_mem(e, 64'h1122_3344_8066_7788, 1, 0, o);
    checks++;
    if (o.wb_wdata !== 64'h80) begin
      failures++; $display("FAIL lbu_zext got=%h exp=80", o.wb_wdata);
    end
  endtask

  task automatic test_store_word();
    obs_t    o;
    ex_mem_t e;
    e = make_inst(OpSw, 64'h8000_0004, 64'hdead_beef, 5'd6);
    drive_mem(e, 64'h0, 3, 0, o);
    checks++;
    if (o.strobe !== 8'hf0) begin failures++; $display("FAIL sw_strobe got=%h exp=f0", o.strobe); end
    checks++;
    if (o.data[63:32] !== 32'hdead_beef || o.size !== MsizeW) begin
      failures++; $display("FAIL sw_data got=%h size=%0d exp deadbeef/2", o.data[63:32], o.size);
    end
  endtask

  task automatic test_stall_no_reissue();
    obs_t    o;
    ex_mem_t e;
    e = make_inst(OpLd, 64'h8000_0010, 64'h0, 5'd8);
    drive_mem(e, 64'h0123_4567_89ab_cdef, 2, 5, o);
    checks++;
    if (o.pulses != 1) begin failures++; $display("FAIL stall_pulses got=%0d exp=1", o.pulses); end
    checks++;
    if (!o.fwd_stable || o.fwd_data !== 64'h0123_4567_89ab_cdef || o.fwd_en !== 1'b1) begin
      failures++;
      $display("FAIL stall_fwd stable=%b en=%b data=%h exp 1/1/0123456789abcdef", o.fwd_stable,
               o.fwd_en, o.fwd_data);
    end
  endtask

  task automatic test_alu();
    ex_mem_t e;
    e             = make_inst(OpAlu, {$urandom, $urandom}, 64'h0, 5'd9);
    e.csr         = '{we: 1'b1, addr: 12'h300, wdata: 64'hcafe};
    e.jump        = 1'b1;
    e.trap        = '{valid: 1'b1, mcause: 4'd3, mtval: 64'h1234};
    @(negedge clk);
    ex_mem_state = e;
    dresp        = '0;
    #1;
    checks++;
    if (ok !== 1'b1 || dreq.valid !== 1'b0) begin
      failures++; $display("FAIL alu_ok ok=%b dreq_valid=%b exp 1/0", ok, dreq.valid);
    end
    checks++;
    if (mem_wb_state.valid !== 1'b1 || mem_wb_state.wdata !== e.alu_result) begin
      failures++;
      $display("FAIL alu_wb valid=%b wdata=%h exp 1/%h", mem_wb_state.valid, mem_wb_state.wdata,
               e.alu_result);
    end
    checks++;
    if (mem_wb_state.csr !== e.csr || mem_wb_state.jump !== e.jump || mem_wb_state.trap !== e.trap ||
        mem_wb_state.pc !== e.pc || mem_wb_state.inst_counter !== e.inst_counter) begin
      failures++;
      $display("FAIL alu_passthru csr=%h jump=%b trap=%h exp %h/%b/%h", mem_wb_state.csr,
               mem_wb_state.jump, mem_wb_state.trap, e.csr, e.jump, e.trap);
    end
    checks++;
    if (forward.enable !== 1'b1 || forward.dest !== 5'd9 || forward.data !== e.alu_result) begin
      failures++;
      $display("FAIL alu_fwd en=%b dest=%0d data=%h exp 1/9/%h", forward.enable, forward.dest,
               forward.data, e.alu_result);
    end
    ex_mem_state.rd = 5'd0;
    #1;
    checks++;
    if (forward.enable !== 1'b0) begin
      failures++; $display("FAIL alu_rd0_fwd got=%b exp=0", forward.enable);
    end
    ex_mem_state.valid = 1'b0;
    #1;
    checks++;
    if (ok !== 1'b1 || mem_wb_state.valid !== 1'b0 || dreq.valid !== 1'b0) begin
      failures++;
      $display("FAIL invalid_inst ok=%b wb_valid=%b dreq=%b exp 1/0/0", ok, mem_wb_state.valid,
               dreq.valid);
    end
  endtask

  task automatic test_reset_mid_req();
    obs_t    o;
    ex_mem_t e;
    int      wait_cyc;
    e = make_inst(OpLd, 64'h8000_0020, 64'h0, 5'd7);
    @(negedge clk);
    ex_mem_state = e;
    dresp        = '0;
    wait_cyc     = 0;
    #1;
    while (dreq.valid !== 1'b1 && wait_cyc < 10) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    checks++;
    if (dreq.valid !== 1'b1) begin
      failures++; $display("FAIL rst_req_issue got=%b exp=1", dreq.valid);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (dreq.valid !== 1'b0) begin
      failures++; $display("FAIL rst_req_drop got=%b exp=0", dreq.valid);
    end
    reset              = 1'b0;
    ex_mem_state.valid = 1'b0;
    dresp.data_ok      = 1'b1;
    dresp.data         = 64'hbad0_bad0_bad0_bad0;
    @(negedge clk);
    #1;
    checks++;
    if (dreq.valid !== 1'b0 || ok !== 1'b1 || mem_wb_state.valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_stale_reply dreq=%b ok=%b wb_valid=%b exp 0/1/0", dreq.valid, ok,
               mem_wb_state.valid);
    end
    dresp = '0;
    e = make_inst(OpLd, 64'h8000_0020, 64'h0, 5'd7);
    drive_mem(e, 64'h5555_aaaa_1234_5678, 1, 0, o);
    checks++;
    if (o.wb_wdata !== 64'h5555_aaaa_1234_5678 || o.pulses != 1) begin
      failures++;
      $display("FAIL rst_fresh_load wdata=%h pulses=%0d exp 5555aaaa12345678/1", o.wb_wdata,
               o.pulses);
    end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    ex_mem_t e;
    e = make_inst(OpLw, 64'h8000_0002, 64'h0, 5'd3);
    @(negedge clk);
    ex_mem_state = e;
    dresp        = '0;
    #1;
    checks++;
    if (ok !== 1'b1 || dreq.valid !== 1'b0 || mem_wb_state.valid !== 1'b1) begin
      failures++;
      $display("FAIL mis_lw_ok ok=%b dreq=%b wb_valid=%b exp 1/0/1", ok, dreq.valid,
               mem_wb_state.valid);
    end
    checks++;
    if (mem_wb_state.trap.valid !== 1'b1 || mem_wb_state.trap.mcause !== 4'd4 ||
        mem_wb_state.trap.mtval !== 64'h8000_0002) begin
      failures++;
      $display("FAIL mis_lw_trap got=%h exp valid/4/80000002", mem_wb_state.trap);
    end
    checks++;
    if (forward.enable !== 1'b0 || mem_wb_state.wen !== 1'b0) begin
      failures++;
      $display("FAIL mis_lw_rd fwd=%b wen=%b exp 0/0", forward.enable, mem_wb_state.wen);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dreq.valid !== 1'b0) begin
      failures++; $display("FAIL mis_lw_noreq got=%b exp=0", dreq.valid);
    end
    e = make_inst(OpSh, 64'h8000_0011, 64'hbeef, 5'd0);
    ex_mem_state = e;
    #1;
    checks++;
    if (mem_wb_state.trap.mcause !== 4'd6 || mem_wb_state.trap.valid !== 1'b1 || ok !== 1'b1) begin
      failures++;
      $display("FAIL mis_sh_trap got=%h ok=%b exp mcause 6", mem_wb_state.trap, ok);
    end
    ex_mem_state.valid = 1'b0;
  endtask
`endif

  task automatic test_random();
    op_t     ops[12] = '{OpLb, OpLh, OpLw, OpLd, OpLbu, OpLhu, OpLwu, OpSb, OpSh, OpSw, OpSd, OpAlu};
    obs_t    o;
    ex_mem_t e;
    op_t     op;
    int      n, off, lat;
    word_t   rdata, exp_w;
    bit      ld, st, exp_fwd;
    for (int it = 0; it < 30; it++) begin
      op    = ops[$urandom_range(0, 11)];
      n     = ref_nbytes(op);
      off   = $urandom_range(0, (8 / n) - 1) * n;
      lat   = $urandom_range(1, 4);
      rdata = {$urandom, $urandom};
      e     = make_inst(op, {$urandom, 29'($urandom), 3'(off)}, {$urandom, $urandom},
                        5'($urandom_range(0, 31)));
      ld    = ref_is_load(op);
      st    = ref_is_store(op);
      drive_mem(e, rdata, lat, $urandom_range(0, 2), o);
      exp_w   = st ? 64'h0 : (ld ? ref_load(op, rdata, off) : e.alu_result);
      exp_fwd = !st && (e.rd != 5'd0);
      checks++;
      if (o.timeout || o.ok_low != ((ld || st) ? lat + 1 : 0) || o.pulses != ((ld || st) ? 1 : 0)) begin
        failures++;
        $display("FAIL rnd_timing it=%0d op=%0d ok_low=%0d pulses=%0d lat=%0d", it, op, o.ok_low,
                 o.pulses, lat);
      end
      checks++;
      if (o.wb_wdata !== exp_w || o.fwd_en !== exp_fwd || (exp_fwd && o.fwd_data !== exp_w)) begin
        failures++;
        $display("FAIL rnd_result it=%0d op=%0d wdata=%h exp=%h fwd_en=%b exp=%b", it, op,
                 o.wb_wdata, exp_w, o.fwd_en, exp_fwd);
      end
      if (ld || st) begin
        checks++;
        if (o.strobe !== ref_strobe(n, off) || o.size !== ref_size(n) || o.addr !== e.alu_result ||
            !o.stable || (st && o.data !== (e.write_mem_data << (8 * off)))) begin
          failures++;
          $display("FAIL rnd_req it=%0d op=%0d strobe=%h exp=%h data=%h stable=%b", it, op,
                   o.strobe, ref_strobe(n, off), o.data, o.stable);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_dword();
    test_load_byte();
    test_store_word();
    test_stall_no_reissue();
    test_alu();
    test_reset_mid_req();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
